// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared sizes, types and popcount helper for the scoreboarded register file
package reg_file_pkg;
  localparam int W_DEF     = 8;
  localparam int D_DEF     = 3;
  localparam int DEPTH     = 2 ** D_DEF;
  localparam int MAX_DEPTH = 64;

  typedef logic [D_DEF-1:0] addr_t;
  typedef logic [W_DEF-1:0] data_t;
  typedef logic [DEPTH-1:0] busy_t;

  function automatic logic [6:0] popcount(input logic [MAX_DEPTH-1:0] v);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < MAX_DEPTH; i++) n = n + {6'd0, v[i]};
    return n;
  endfunction
endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// rtl/reg_file_sb_scoreboard.sv - busy bits, pending count and hazard pulse for reg_file_sb
module busy_scoreboard
  import reg_file_pkg::*;
#(
  parameter int D        = 3,
  parameter int ZERO_REG = 1
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic             Reserve_en,
  input  logic [D-1:0]     Reserve_address,
  input  logic             Fill_en,
  input  logic [D-1:0]     Fill_address,
  input  logic             Reg_write_en,
  input  logic [D-1:0]     Reg_write_address,
  output logic [2**D-1:0]  Busy_vector,
  output logic [D:0]       Pending_count,
  output logic             Collision_err
);
  localparam int N_REGS = 2 ** D;

  logic [N_REGS-1:0]    r_busy;
  logic [D:0]           r_count;
  logic                 r_err;
  logic [N_REGS-1:0]    w_busy_next;
  logic [MAX_DEPTH-1:0] w_busy_ext;
  logic [6:0]           w_cnt;
  logic                 w_err;
  logic                 w_res_ok;
  logic                 w_fill_ok;
  logic                 w_wr_ok;

  // Hardwired-zero register 0 swallows every strobe without complaint.
  assign w_res_ok  = Reserve_en   && !(ZERO_REG != 0 && Reserve_address   == '0);
  assign w_fill_ok = Fill_en      && !(ZERO_REG != 0 && Fill_address      == '0);
  assign w_wr_ok   = Reg_write_en && !(ZERO_REG != 0 && Reg_write_address == '0);

  always_comb begin
    w_busy_next = r_busy;
    if (w_fill_ok) w_busy_next[Fill_address] = 1'b0;
    if (w_res_ok)  w_busy_next[Reserve_address] = 1'b1;

    w_busy_ext = '0;
    w_busy_ext[N_REGS-1:0] = w_busy_next;

    w_err = 1'b0;
    if (w_wr_ok && w_fill_ok && Reg_write_address == Fill_address) w_err = 1'b1;
    if (w_wr_ok && r_busy[Reg_write_address] &&
        !(w_fill_ok && Fill_address == Reg_write_address)) w_err = 1'b1;
    if (w_res_ok && r_busy[Reserve_address] &&
        !(w_fill_ok && Fill_address == Reserve_address)) w_err = 1'b1;
    // A fill paired with a reserve of the same register is a back-to-back reuse, not a stray fill.
    if (w_fill_ok && !r_busy[Fill_address] &&
        !(w_res_ok && Reserve_address == Fill_address)) w_err = 1'b1;
  end

  assign w_cnt = popcount(w_busy_ext);

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_busy  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_busy  <= w_busy_next;
      r_count <= w_cnt[D:0];
      r_err   <= w_err;
    end
  end

  assign Busy_vector   = r_busy;
  assign Pending_count = r_count;
  assign Collision_err = r_err;
endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - scoreboarded register file with bypassed combinational read ports
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int W        = 8,
  parameter int D        = 3,
  parameter int NR       = 2,
  parameter int ZERO_REG = 1
) (
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic [NR*D-1:0]   Reg_read_address,
  output logic [NR*W-1:0]   Read_data,
  output logic [NR-1:0]     Read_ready,
  input  logic              Reg_write_en,
  input  logic [D-1:0]      Reg_write_address,
  input  logic [W-1:0]      Reg_write_data,
  input  logic              Reserve_en,
  input  logic [D-1:0]      Reserve_address,
  input  logic              Fill_en,
  input  logic [D-1:0]      Fill_address,
  input  logic [W-1:0]      Fill_data,
  output logic [2**D-1:0]   Busy_vector,
  output logic [D:0]        Pending_count,
  output logic              Collision_err
);
  localparam int N_REGS = 2 ** D;

  logic [W-1:0] r_regs [N_REGS];
  logic         w_fill_ok;
  logic         w_wr_ok;

  assign w_fill_ok = Fill_en      && !(ZERO_REG != 0 && Fill_address      == '0);
  assign w_wr_ok   = Reg_write_en && !(ZERO_REG != 0 && Reg_write_address == '0);

  busy_scoreboard #(.D(D), .ZERO_REG(ZERO_REG)) u_sb (
    .CLK               (CLK),
    .Reset_n           (Reset_n),
    .Reserve_en        (Reserve_en),
    .Reserve_address   (Reserve_address),
    .Fill_en           (Fill_en),
    .Fill_address      (Fill_address),
    .Reg_write_en      (Reg_write_en),
    .Reg_write_address (Reg_write_address),
    .Busy_vector       (Busy_vector),
    .Pending_count     (Pending_count),
    .Collision_err     (Collision_err)
  );

  // Immediate write is issued later than the fill it may collide with, so it lands last.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < N_REGS; i++) r_regs[i] <= '0;
    end else begin
      if (w_fill_ok) r_regs[Fill_address] <= Fill_data;
      if (w_wr_ok)   r_regs[Reg_write_address] <= Reg_write_data;
    end
  end

  for (genvar g = 0; g < NR; g++) begin : g_rd
    logic [D-1:0] w_addr;
    logic         w_zero;
    logic         w_fill_hit;
    logic [W-1:0] w_data;

    assign w_addr     = Reg_read_address[g*D +: D];
    assign w_zero     = (ZERO_REG != 0) && (w_addr == '0);
    assign w_fill_hit = Fill_en && (Fill_address == w_addr);

    always_comb begin
      w_data = r_regs[w_addr];
      if (w_zero)                                        w_data = '0;
      else if (Reg_write_en && Reg_write_address == w_addr) w_data = Reg_write_data;
      else if (w_fill_hit)                               w_data = Fill_data;
    end

    assign Read_data[g*W +: W] = w_data;
    assign Read_ready[g]       = w_zero || !Busy_vector[w_addr] || w_fill_hit;
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - directed self-checking bench for reg_file_sb
module tb_reg_file_sb;
  localparam int W  = 8;
  localparam int D  = 3;
  localparam int NR = 2;

  logic            CLK = 1'b0;
  logic            Reset_n;
  logic [NR*D-1:0] Reg_read_address;
  logic [NR*W-1:0] Read_data;
  logic [NR-1:0]   Read_ready;
  logic            Reg_write_en;
  logic [D-1:0]    Reg_write_address;
  logic [W-1:0]    Reg_write_data;
  logic            Reserve_en;
  logic [D-1:0]    Reserve_address;
  logic            Fill_en;
  logic [D-1:0]    Fill_address;
  logic [W-1:0]    Fill_data;
  logic [2**D-1:0] Busy_vector;
  logic [D:0]      Pending_count;
  logic            Collision_err;

  int checks   = 0;
  int failures = 0;

  reg_file_sb #(.W(W), .D(D), .NR(NR), .ZERO_REG(1)) dut (
    .CLK               (CLK),
    .Reset_n           (Reset_n),
    .Reg_read_address  (Reg_read_address),
    .Read_data         (Read_data),
    .Read_ready        (Read_ready),
    .Reg_write_en      (Reg_write_en),
    .Reg_write_address (Reg_write_address),
    .Reg_write_data    (Reg_write_data),
    .Reserve_en        (Reserve_en),
    .Reserve_address   (Reserve_address),
    .Fill_en           (Fill_en),
    .Fill_address      (Fill_address),
    .Fill_data         (Fill_data),
    .Busy_vector       (Busy_vector),
    .Pending_count     (Pending_count),
    .Collision_err     (Collision_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    Reg_write_en = 1'b0; Reg_write_address = '0; Reg_write_data = '0;
    Reserve_en   = 1'b0; Reserve_address   = '0;
    Fill_en      = 1'b0; Fill_address      = '0; Fill_data      = '0;
  endtask

  task automatic rd(input logic [D-1:0] a0, input logic [D-1:0] a1);
    Reg_read_address = {a1, a0};
  endtask

  task automatic wr(input logic [D-1:0] a, input logic [W-1:0] d);
    Reg_write_en = 1'b1; Reg_write_address = a; Reg_write_data = d;
  endtask

  task automatic rsv(input logic [D-1:0] a);
    Reserve_en = 1'b1; Reserve_address = a;
  endtask

  task automatic fil(input logic [D-1:0] a, input logic [W-1:0] d);
    Fill_en = 1'b1; Fill_address = a; Fill_data = d;
  endtask

  initial begin
    Reset_n = 1'b0;
    idle();
    rd(3'd0, 3'd0);
    repeat (2) tick();
    chk("reset_busy", 32'(Busy_vector), 32'h00);
    chk("reset_count", 32'(Pending_count), 32'd0);
    chk("reset_err", 32'(Collision_err), 32'd0);
    Reset_n = 1'b1;
    tick();

    // 1: asynchronous reset mid-cycle wipes data and reservations
    wr(3'd3, 8'h5A); rsv(3'd5);
    tick();
    idle(); rd(3'd3, 3'd5);
    #1;
    chk("t1_r3_stored", 32'(Read_data[7:0]), 32'h5A);
    chk("t1_r5_busy", 32'(Read_ready[1]), 32'd0);
    #2 Reset_n = 1'b0;
    #1;
    chk("t1_r3_after_rst", 32'(Read_data[7:0]), 32'h00);
    chk("t1_busy_after_rst", 32'(Busy_vector), 32'h00);
    chk("t1_count_after_rst", 32'(Pending_count), 32'd0);
    chk("t1_ready_after_rst", 32'(Read_ready), 32'b11);
    tick();
    Reset_n = 1'b1;
    tick();

    // 2: write-to-read bypass
    wr(3'd2, 8'h11); rd(3'd2, 3'd0);
    #1;
    chk("t2_bypass_data", 32'(Read_data[7:0]), 32'h11);
    chk("t2_bypass_ready", 32'(Read_ready[0]), 32'd1);
    tick();
    idle();
    #1;
    chk("t2_stored", 32'(Read_data[7:0]), 32'h11);

    // 3: reserve, stall, fill
    rsv(3'd5); rd(3'd0, 3'd5);
    tick();
    idle();
    #1;
    chk("t3_not_ready", 32'(Read_ready[1]), 32'd0);
    chk("t3_count1", 32'(Pending_count), 32'd1);
    chk("t3_busy", 32'(Busy_vector), 32'h20);
    fil(3'd5, 8'hC3);
    #1;
    chk("t3_fill_bypass", 32'(Read_data[15:8]), 32'hC3);
    chk("t3_fill_ready", 32'(Read_ready[1]), 32'd1);
    tick();
    idle();
    #1;
    chk("t3_busy_clear", 32'(Busy_vector), 32'h00);
    chk("t3_count0", 32'(Pending_count), 32'd0);
    chk("t3_no_err", 32'(Collision_err), 32'd0);
    chk("t3_stored", 32'(Read_data[15:8]), 32'hC3);

    // 4: hazards
    rsv(3'd4);
    tick();
    idle();
    chk("t4_rsv_no_err", 32'(Collision_err), 32'd0);
    wr(3'd4, 8'h22);
    tick();
    idle(); rd(3'd4, 3'd6);
    #1;
    chk("t4_wr_busy_err", 32'(Collision_err), 32'd1);
    chk("t4_still_busy", 32'(Busy_vector), 32'h10);
    chk("t4_r4_data", 32'(Read_data[7:0]), 32'h22);
    chk("t4_r4_not_ready", 32'(Read_ready[0]), 32'd0);
    tick();
    chk("t4_err_one_cycle", 32'(Collision_err), 32'd0);
    fil(3'd6, 8'h77);
    tick();
    idle();
    #1;
    chk("t4_stray_fill_err", 32'(Collision_err), 32'd1);
    chk("t4_r6_data", 32'(Read_data[15:8]), 32'h77);
    chk("t4_busy_unchanged", 32'(Busy_vector), 32'h10);
    rsv(3'd4);
    tick();
    idle();
    chk("t4_rsv_busy_err", 32'(Collision_err), 32'd1);
    chk("t4_rsv_busy_count", 32'(Pending_count), 32'd1);
    wr(3'd4, 8'h44); fil(3'd4, 8'h33);
    tick();
    idle();
    #1;
    chk("t4_wr_fill_err", 32'(Collision_err), 32'd1);
    chk("t4_wr_fill_newer", 32'(Read_data[7:0]), 32'h44);
    chk("t4_wr_fill_clears", 32'(Busy_vector), 32'h00);
    tick();

    // 5: hardwired zero register
    wr(3'd0, 8'hFF); rsv(3'd0); rd(3'd0, 3'd0);
    #1;
    chk("t5_r0_bypass", 32'(Read_data[7:0]), 32'h00);
    chk("t5_r0_ready", 32'(Read_ready[0]), 32'd1);
    tick();
    idle();
    #1;
    chk("t5_r0_stored", 32'(Read_data[7:0]), 32'h00);
    chk("t5_no_err", 32'(Collision_err), 32'd0);
    chk("t5_no_busy", 32'(Busy_vector), 32'h00);

    // 6: fill the scoreboard
    for (int i = 1; i < 8; i++) begin
      rsv(3'(i));
      tick();
      idle();
      chk("t6_rsv_no_err", 32'(Collision_err), 32'd0);
    end
    chk("t6_count7", 32'(Pending_count), 32'd7);
    chk("t6_busy_all", 32'(Busy_vector), 32'hFE);
    rsv(3'd1); fil(3'd1, 8'h99); rd(3'd1, 3'd2);
    #1;
    chk("t6_fill_ready", 32'(Read_ready[0]), 32'd1);
    chk("t6_fill_data", 32'(Read_data[7:0]), 32'h99);
    chk("t6_other_stall", 32'(Read_ready[1]), 32'd0);
    tick();
    idle();
    #1;
    chk("t6_count_still7", 32'(Pending_count), 32'd7);
    chk("t6_rsv_fill_no_err", 32'(Collision_err), 32'd0);
    chk("t6_busy_still_all", 32'(Busy_vector), 32'hFE);
    chk("t6_r1_stored", 32'(Read_data[7:0]), 32'h99);
    chk("t6_r1_busy_again", 32'(Read_ready[0]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
